// File: rtl/display_compositor_if.sv
// display_compositor_if
//   Bundles the pixel-stream, IR and box-description signals of the display
//   compositor so the sprite logic (master) and the compositor (slave) share a
//   single connection point.
//   Signals:
//     ir_in, ir_valid_in            decoded IR code and its one-cycle strobe
//     nf_in                         new-frame strobe
//     hcount_in, vcount_in          current pixel coordinates
//     camera_sw, camera_pixel_in    background select and camera RGB
//     start_pixel_in                menu-screen RGB
//     box_*_in                      packed per-box enable, bounds and colour
//     pixel_out, mode_out           composited RGB and active mode
interface display_compositor_if #(
  parameter int NUM_BOXES = 4
);
  logic [31:0]             ir_in;
  logic                    ir_valid_in;
  logic                    nf_in;
  logic [10:0]             hcount_in;
  logic [9:0]              vcount_in;
  logic                    camera_sw;
  logic [23:0]             camera_pixel_in;
  logic [23:0]             start_pixel_in;
  logic [NUM_BOXES-1:0]    box_en_in;
  logic [NUM_BOXES*12-1:0] box_x_in;
  logic [NUM_BOXES*11-1:0] box_y_in;
  logic [NUM_BOXES*12-1:0] box_xmax_in;
  logic [NUM_BOXES*11-1:0] box_ymax_in;
  logic [NUM_BOXES*24-1:0] box_color_in;
  logic [23:0]             pixel_out;
  logic [1:0]              mode_out;

  modport master (
    output ir_in, ir_valid_in, nf_in, hcount_in, vcount_in, camera_sw,
           camera_pixel_in, start_pixel_in, box_en_in, box_x_in, box_y_in,
           box_xmax_in, box_ymax_in, box_color_in,
    input  pixel_out, mode_out
  );

  modport slave (
    input  ir_in, ir_valid_in, nf_in, hcount_in, vcount_in, camera_sw,
           camera_pixel_in, start_pixel_in, box_en_in, box_x_in, box_y_in,
           box_xmax_in, box_ymax_in, box_color_in,
    output pixel_out, mode_out
  );
endinterface

// File: rtl/display_compositor.sv
// display_compositor
//   Composites NUM_BOXES prioritised colour boxes, a game border and the
//   camera feed into one 24-bit pixel, with a fixed two-cycle latency. Owns
//   the IR-driven MENU/PLAY/PAUSED mode FSM; mode changes are held pending
//   and only take effect on the new-frame strobe.
//   Ports:
//     clk_in   pixel clock
//     rst_in   asynchronous reset, active-high
//     bus      display_compositor_if slave: IR, frame strobe, pixel
//              coordinates, camera/menu pixels, box descriptions in;
//              pixel_out and mode_out out
module display_compositor #(
  parameter int          NUM_BOXES    = 4,
  parameter int          BORDER_X     = 960,
  parameter int          BORDER_Y     = 640,
  parameter logic [31:0] IR_START     = 32'h20DF_5BA4,
  parameter logic [31:0] IR_PAUSE     = 32'h20DF_5AA5,
  parameter int          BLINK_FRAMES = 30
) (
  input logic                 clk_in,
  input logic                 rst_in,
  display_compositor_if.slave bus
);

  localparam logic [1:0] MODE_MENU   = 2'd0;
  localparam logic [1:0] MODE_PLAY   = 2'd1;
  localparam logic [1:0] MODE_PAUSED = 2'd2;

  localparam int          CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [10:0] BORDER_X_C = 11'(BORDER_X);
  localparam logic [9:0]  BORDER_Y_C = 10'(BORDER_Y);

  logic [1:0]           mode;
  logic [1:0]           pend_mode;
  logic                 pend_valid;
  logic                 dec_valid;
  logic [1:0]           dec_mode;
  logic                 enter_paused;
  logic [CNT_W-1:0]     frame_cnt;
  logic                 blink;

  logic [NUM_BOXES-1:0] hit;
  logic [23:0]          hit_color;
  logic                 border_hit;
  logic [11:0]          h_ext;
  logic [10:0]          v_ext;

  logic [NUM_BOXES-1:0] s1_hit;
  logic [23:0]          s1_color;
  logic                 s1_border;
  logic [23:0]          s1_bg;
  logic [23:0]          s1_start;
  logic [1:0]           s1_mode;

  logic [23:0]          pixel_next;
  logic [23:0]          pixel_q;

  // Decode the IR code against the active mode (never the pending one).
  always_comb begin
    dec_valid = 1'b0;
    dec_mode  = MODE_MENU;
    if (bus.ir_valid_in) begin
      case (mode)
        MODE_MENU: begin
          if (bus.ir_in == IR_START) begin
            dec_valid = 1'b1;
            dec_mode  = MODE_PLAY;
          end
        end
        MODE_PLAY: begin
          if (bus.ir_in == IR_PAUSE) begin
            dec_valid = 1'b1;
            dec_mode  = MODE_PAUSED;
          end
        end
        MODE_PAUSED: begin
          if (bus.ir_in == IR_PAUSE) begin
            dec_valid = 1'b1;
            dec_mode  = MODE_PLAY;
          end else if (bus.ir_in == IR_START) begin
            dec_valid = 1'b1;
            dec_mode  = MODE_MENU;
          end
        end
        default: begin
          dec_valid = 1'b0;
        end
      endcase
    end
  end

  // A frame strobe applies whatever was pending before this cycle; a code
  // decoded in the same cycle becomes the new pending value instead of being
  // cleared, so it waits for the following frame.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mode       <= MODE_MENU;
      pend_mode  <= MODE_MENU;
      pend_valid <= 1'b0;
    end else begin
      if (bus.nf_in && pend_valid) begin
        mode <= pend_mode;
      end
      if (dec_valid) begin
        pend_valid <= 1'b1;
        pend_mode  <= dec_mode;
      end else if (bus.nf_in) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign enter_paused = bus.nf_in && pend_valid &&
                        (pend_mode == MODE_PAUSED) && (mode != MODE_PAUSED);

  // Blink half-period counter; only runs while paused and restarts on entry.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (enter_paused) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if ((mode == MODE_PAUSED) && bus.nf_in) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign h_ext = {1'b0, bus.hcount_in};
  assign v_ext = {1'b0, bus.vcount_in};

  // Inverted bounds fail one of the two comparisons, so such a box never hits.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_BOXES; i++) begin
      hit[i] = bus.box_en_in[i] &&
               (bus.box_x_in[12*i +: 12] <= h_ext) && (h_ext <= bus.box_xmax_in[12*i +: 12]) &&
               (bus.box_y_in[11*i +: 11] <= v_ext) && (v_ext <= bus.box_ymax_in[11*i +: 11]);
    end
  end

  // Walk from lowest priority upward so box 0 ends up winning.
  always_comb begin
    hit_color = 24'h0;
    for (int i = NUM_BOXES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_color = bus.box_color_in[24*i +: 24];
      end
    end
  end

  assign border_hit = ((bus.hcount_in == BORDER_X_C) && (bus.vcount_in <= BORDER_Y_C)) ||
                      ((bus.vcount_in == BORDER_Y_C) && (bus.hcount_in <= BORDER_X_C));

  // Stage 1 captures the mode alongside the pixel so a frame switch lines up
  // with the pixel data two cycles after the strobe.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_hit    <= '0;
      s1_color  <= 24'h0;
      s1_border <= 1'b0;
      s1_bg     <= 24'h0;
      s1_start  <= 24'h0;
      s1_mode   <= MODE_MENU;
    end else begin
      s1_hit    <= hit;
      s1_color  <= hit_color;
      s1_border <= border_hit;
      s1_bg     <= bus.camera_sw ? bus.camera_pixel_in : 24'h0;
      s1_start  <= bus.start_pixel_in;
      s1_mode   <= mode;
    end
  end

  // Blink dims box colours only; border and background stay untouched.
  always_comb begin
    pixel_next = s1_bg;
    if (s1_mode == MODE_MENU) begin
      pixel_next = s1_start;
    end else if (s1_border) begin
      pixel_next = 24'hFFFFFF;
    end else if (|s1_hit) begin
      if ((s1_mode == MODE_PAUSED) && blink) begin
        pixel_next = {1'b0, s1_color[23:17], 1'b0, s1_color[15:9], 1'b0, s1_color[7:1]};
      end else begin
        pixel_next = s1_color;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_q <= 24'h0;
    end else begin
      pixel_q <= pixel_next;
    end
  end

  assign bus.pixel_out = pixel_q;
  assign bus.mode_out  = mode;

endmodule
